// File: rtl/async_handshake_pkg.sv
// Shared definitions for the 2-phase async handshake source.
// Holds the FSM state encoding and the default parameter values
// used by async_handshake_source and its ack synchronizer.
package async_handshake_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } hsState_t;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_SYNC_DEPTH = 3;
    localparam int DEF_TIMEOUT    = 1023;

    // Watchdog counter width; TIMEOUT must fit in it.
    localparam int WDOG_W = 16;

endpackage

// File: rtl/async_reset_sync_shift_reg.sv
// Multi-flop synchronizer shift register with asynchronous active-high
// reset to zero.
// Ports:
//   clock - sampling clock
//   reset - async active-high reset, clears every stage
//   d     - asynchronous input (WIDTH bits)
//   q     - synchronized output, DEPTH clock edges behind d
module async_reset_sync_shift_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [DEPTH-1:0][WIDTH-1:0] stages;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[DEPTH-2:0], d};
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/async_handshake_source.sv
// Source side of a 2-phase (toggle) request/ack clock-domain crossing.
// A word offered on the enq port is captured into io_async_data and
// announced by toggling io_async_req; the next word is only accepted
// once the sink's returning ack toggle has been synchronized back.
// Ports:
//   clock, reset    - clock and async active-high reset
//   io_enq_valid    - producer offers io_enq_bits
//   io_enq_ready    - word accepted this cycle when valid is also high
//   io_enq_bits     - offered word
//   io_async_req    - registered request toggle to the sink domain
//   io_async_data   - registered word, held while a transfer is outstanding
//   io_async_ack    - ack toggle from the sink domain (asynchronous)
//   io_busy         - transfer outstanding
//   io_timeout      - sticky flag: a transfer waited TIMEOUT cycles
module async_handshake_source
    import async_handshake_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int SYNC_DEPTH = DEF_SYNC_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_enq_valid,
    output logic              io_enq_ready,
    input  logic [DATA_W-1:0] io_enq_bits,
    output logic              io_async_req,
    output logic [DATA_W-1:0] io_async_data,
    input  logic              io_async_ack,
    output logic              io_busy,
    output logic              io_timeout
);

    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);
    localparam logic [WDOG_W-1:0] WDOG_PRE   = WDOG_W'(TIMEOUT - 1);

    hsState_t          state;
    hsState_t          stateNext;
    logic              ackS;
    logic              accept;
    logic [WDOG_W-1:0] wdog;

    // The only consumer of io_async_ack.
    async_reset_sync_shift_reg #(
        .WIDTH (1),
        .DEPTH (SYNC_DEPTH)
    ) ackSync (
        .clock (clock),
        .reset (reset),
        .d     (io_async_ack),
        .q     (ackS)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ackS != req in IDLE means the sink is out of step (e.g. it was not
    // reset with us); hold ready low until it catches up.
    always_comb begin
        stateNext    = state;
        io_enq_ready = 1'b0;
        io_busy      = 1'b0;
        case (state)
            IDLE: begin
                io_enq_ready = (ackS == io_async_req);
                if (io_enq_valid && io_enq_ready) begin
                    stateNext = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                io_busy = 1'b1;
                if (ackS == io_async_req) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign accept = io_enq_valid && io_enq_ready;

    // Data/req only move on accept, which can only happen in IDLE, so both
    // are frozen for the whole of WAIT_ACK.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_async_data <= '0;
            io_async_req  <= 1'b0;
        end else if (accept) begin
            io_async_data <= io_enq_bits;
            io_async_req  <= ~io_async_req;
        end
    end

    // Watchdog only flags a slow sink; the transfer keeps waiting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wdog       <= '0;
            io_timeout <= 1'b0;
        end else begin
            if (accept) begin
                wdog <= '0;
            end else if (state == WAIT_ACK && wdog != WDOG_LIMIT) begin
                wdog <= wdog + 1'b1;
            end
            // Set on the same edge the counter reaches the limit.
            if (state == WAIT_ACK && wdog == WDOG_PRE) begin
                io_timeout <= 1'b1;
            end
        end
    end

endmodule
